register_file_param: RTL and testbench

- Parametrised next-generation register file for the single-cycle/pipelined MIPS datapath: 2 asynchronous read ports, 1 synchronous write port, register 0 hardwired to zero.
- Adds over the previous generation:
  - write-to-read bypass;
  - per-register scoreboard, so the pipeline can detect RAW hazards on in-flight loads;
  - a soft-clear sequencer that zeroes the file one register per cycle without asserting reset.

---
 rtl/register_file_param.sv | 142 ++++++++++++++
 tb/tb_register_file_param.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/register_file_param.sv
// register_file_param: parametrised 2-read/1-write register file with write bypass, load scoreboard and soft-clear sweep.
// Latency: reads and hazards are combinational (zero cycles); writes, scoreboard and clear updates land on the next rising edge.
// Backpressure: none; reg_write presented while clr_busy is high is dropped, so the caller holds off until clr_busy falls.
module register_file_param #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              reg_write,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data,
  input  logic [ADDR_W-1:0] read_reg1,
  input  logic [ADDR_W-1:0] read_reg2,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  input  logic              sb_set,
  input  logic [ADDR_W-1:0] sb_reg,
  output logic              hazard1,
  output logic              hazard2,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done
);

  localparam int NREG = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_IDX  = '0;
  localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(1);
  // Sweep ends on the all-ones index, so the counter never has to wrap.
  localparam logic [ADDR_W-1:0] LAST_IDX  = '1;

  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic              r_clr_busy;
  logic              r_clr_done;
  logic [DATA_W-1:0] r_regs [NREG];
  logic [NREG-1:0]   r_sb;

  logic w_idle;
  logic w_clearing;
  logic w_wr_acc;
  logic w_sb_acc;
  logic w_byp1;
  logic w_byp2;
  logic w_reset1;
  logic w_reset2;

  assign w_idle     = (r_state == IDLE);
  assign w_clearing = (r_state == CLEAR);
  // A write only lands when idle and not aimed at the hardwired zero register.
  assign w_wr_acc   = reg_write && (write_reg != ZERO_IDX) && w_idle;
  assign w_sb_acc   = sb_set && (sb_reg != ZERO_IDX);
  // Bypass hits only on accepted writes, which also keeps it off during a sweep.
  assign w_byp1     = (BYPASS != 0) && w_wr_acc && (write_reg == read_reg1);
  assign w_byp2     = (BYPASS != 0) && w_wr_acc && (write_reg == read_reg2);
  // A bypassed write retires the pending load unless a new load re-marks the register.
  assign w_reset1   = w_byp1 && !(w_sb_acc && (sb_reg == read_reg1));
  assign w_reset2   = w_byp2 && !(w_sb_acc && (sb_reg == read_reg2));

  assign read_data1 = (read_reg1 == ZERO_IDX) ? '0 : (w_byp1 ? write_data : r_regs[read_reg1]);
  assign read_data2 = (read_reg2 == ZERO_IDX) ? '0 : (w_byp2 ? write_data : r_regs[read_reg2]);
  assign hazard1    = r_sb[read_reg1] && !w_reset1;
  assign hazard2    = r_sb[read_reg2] && !w_reset2;
  assign clr_busy   = r_clr_busy;
  assign clr_done   = r_clr_done;

  // Register storage: normal writes when idle, sweep zeroes one entry per cycle; entry 0 stays zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else begin
      for (int i = 1; i < NREG; i++) begin
        if (w_wr_acc && (write_reg == ADDR_W'(i))) begin
          r_regs[i] <= write_data;
        end else if (w_clearing && (r_cnt == ADDR_W'(i))) begin
          r_regs[i] <= '0;
        end
      end
    end
  end

  // Scoreboard: a new load mark beats both a retiring write and the sweep on the same register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sb <= '0;
    end else begin
      for (int i = 1; i < NREG; i++) begin
        if (w_sb_acc && (sb_reg == ADDR_W'(i))) begin
          r_sb[i] <= 1'b1;
        end else if (w_wr_acc && (write_reg == ADDR_W'(i))) begin
          r_sb[i] <= 1'b0;
        end else if (w_clearing && (r_cnt == ADDR_W'(i))) begin
          r_sb[i] <= 1'b0;
        end
      end
    end
  end

  // Soft-clear sequencer with registered busy/done flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_clr_busy <= 1'b0;
      r_clr_done <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (clr_req) begin
            r_state    <= CLEAR;
            r_cnt      <= FIRST_IDX;
            r_clr_busy <= 1'b1;
          end
        end
        CLEAR: begin
          if (r_cnt == LAST_IDX) begin
            r_state    <= DONE;
            r_cnt      <= '0;
            r_clr_done <= 1'b1;
          end else begin
            r_cnt <= r_cnt + FIRST_IDX;
          end
        end
        DONE: begin
          r_state    <= IDLE;
          r_clr_busy <= 1'b0;
          r_clr_done <= 1'b0;
        end
        default: begin
          r_state    <= IDLE;
          r_cnt      <= '0;
          r_clr_busy <= 1'b0;
          r_clr_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_register_file_param.sv
// Bench for register_file_param: default instance with bypass, default instance without bypass, 16-bit/8-entry instance.
// Stimulus queues expected output values; a negedge monitor pops and compares them.
module tb_register_file_param;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Shared stimulus for the two 32x32 instances.
  logic        reg_write = 1'b0;
  logic [4:0]  write_reg = '0;
  logic [31:0] write_data = '0;
  logic [4:0]  read_reg1 = '0;
  logic [4:0]  read_reg2 = '0;
  logic        sb_set = 1'b0;
  logic [4:0]  sb_reg = '0;
  logic        clr_req = 1'b0;

  logic [31:0] a_rd1, a_rd2, b_rd1, b_rd2;
  logic        a_hz1, a_hz2, a_busy, a_done;
  logic        b_hz1, b_hz2, b_busy, b_done;

  // Stimulus for the narrow instance.
  logic        c_reg_write = 1'b0;
  logic [2:0]  c_write_reg = '0;
  logic [15:0] c_write_data = '0;
  logic [2:0]  c_read_reg1 = '0;
  logic [2:0]  c_read_reg2 = '0;
  logic        c_sb_set = 1'b0;
  logic [2:0]  c_sb_reg = '0;
  logic        c_clr_req = 1'b0;
  logic [15:0] c_rd1, c_rd2;
  logic        c_hz1, c_hz2, c_busy, c_done;

  register_file_param #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data),
    .read_reg1(read_reg1), .read_reg2(read_reg2), .read_data1(a_rd1), .read_data2(a_rd2),
    .sb_set(sb_set), .sb_reg(sb_reg), .hazard1(a_hz1), .hazard2(a_hz2),
    .clr_req(clr_req), .clr_busy(a_busy), .clr_done(a_done));

  register_file_param #(.DATA_W(32), .ADDR_W(5), .BYPASS(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data),
    .read_reg1(read_reg1), .read_reg2(read_reg2), .read_data1(b_rd1), .read_data2(b_rd2),
    .sb_set(sb_set), .sb_reg(sb_reg), .hazard1(b_hz1), .hazard2(b_hz2),
    .clr_req(clr_req), .clr_busy(b_busy), .clr_done(b_done));

  register_file_param #(.DATA_W(16), .ADDR_W(3), .BYPASS(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .reg_write(c_reg_write), .write_reg(c_write_reg), .write_data(c_write_data),
    .read_reg1(c_read_reg1), .read_reg2(c_read_reg2), .read_data1(c_rd1), .read_data2(c_rd2),
    .sb_set(c_sb_set), .sb_reg(c_sb_reg), .hazard1(c_hz1), .hazard2(c_hz2),
    .clr_req(c_clr_req), .clr_busy(c_busy), .clr_done(c_done));

  localparam int S_RD1A = 0, S_RD2A = 1, S_HZ1A = 2, S_HZ2A = 3, S_BUSYA = 4, S_DONEA = 5;
  localparam int S_RD1B = 6, S_HZ1B = 7, S_BUSYB = 8, S_DONEB = 9;
  localparam int S_RD1C = 10, S_RD2C = 11, S_BUSYC = 12, S_DONEC = 13, S_HZ1C = 14;

  typedef struct {
    int          sig;
    logic [63:0] val;
    int          stp;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  int   n_checks = 0;
  int   n_fail = 0;
  int   stp = 0;

  function automatic logic [63:0] sample(input int sig);
    case (sig)
      S_RD1A:  return 64'(a_rd1);
      S_RD2A:  return 64'(a_rd2);
      S_HZ1A:  return 64'(a_hz1);
      S_HZ2A:  return 64'(a_hz2);
      S_BUSYA: return 64'(a_busy);
      S_DONEA: return 64'(a_done);
      S_RD1B:  return 64'(b_rd1);
      S_HZ1B:  return 64'(b_hz1);
      S_BUSYB: return 64'(b_busy);
      S_DONEB: return 64'(b_done);
      S_RD1C:  return 64'(c_rd1);
      S_RD2C:  return 64'(c_rd2);
      S_BUSYC: return 64'(c_busy);
      S_DONEC: return 64'(c_done);
      S_HZ1C:  return 64'(c_hz1);
      default: return 64'hBAD0_BAD0_BAD0_BAD0;
    endcase
  endfunction

  function automatic string sig_name(input int sig);
    case (sig)
      S_RD1A:  return "a.read_data1";
      S_RD2A:  return "a.read_data2";
      S_HZ1A:  return "a.hazard1";
      S_HZ2A:  return "a.hazard2";
      S_BUSYA: return "a.clr_busy";
      S_DONEA: return "a.clr_done";
      S_RD1B:  return "b.read_data1";
      S_HZ1B:  return "b.hazard1";
      S_BUSYB: return "b.clr_busy";
      S_DONEB: return "b.clr_done";
      S_RD1C:  return "c.read_data1";
      S_RD2C:  return "c.read_data2";
      S_BUSYC: return "c.clr_busy";
      S_DONEC: return "c.clr_done";
      S_HZ1C:  return "c.hazard1";
      default: return "unknown";
    endcase
  endfunction

  // Monitor: all expectations queued during a cycle are checked at that cycle's falling edge.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      cur = q.pop_front();
      n_checks++;
      if (sample(cur.sig) !== cur.val) begin
        n_fail++;
        $display("FAIL %s step %0d: got %h, expected %h", sig_name(cur.sig), cur.stp, sample(cur.sig), cur.val);
      end
    end
  end

  task automatic expect_val(input int sig, input logic [63:0] v);
    exp_t e;
    e.sig = sig;
    e.val = v;
    e.stp = stp;
    q.push_back(e);
  endtask

  // Advance to just after the next rising edge and drop one-shot controls.
  task automatic step();
    @(posedge clk);
    #1;
    stp++;
    reg_write = 1'b0;
    sb_set = 1'b0;
    clr_req = 1'b0;
    c_reg_write = 1'b0;
    c_sb_set = 1'b0;
    c_clr_req = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    reg_write = 1'b1;
    write_reg = a;
    write_data = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    read_reg1 = 5'd5;
    read_reg2 = 5'd9;
    c_read_reg1 = 3'd3;
    #2;
    expect_val(S_RD1A, 0); expect_val(S_RD2A, 0); expect_val(S_HZ1A, 0); expect_val(S_HZ2A, 0);
    expect_val(S_BUSYA, 0); expect_val(S_DONEA, 0); expect_val(S_RD1C, 0); expect_val(S_BUSYC, 0);
    step();
    step();
    rst_n = 1'b1;

    // 1: basic write/read and register 0.
    wr(5'd5, 32'hDEADBEEF); read_reg1 = 5'd0; read_reg2 = 5'd0;
    step();
    read_reg1 = 5'd5; read_reg2 = 5'd0;
    #1;
    n_checks++;
    if (a_rd1 !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL a.read_data1 direct step %0d: got %h, expected %h", stp, a_rd1, 32'hDEADBEEF);
    end
    n_checks++;
    if (b_rd1 !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL b.read_data1 direct step %0d: got %h, expected %h", stp, b_rd1, 32'hDEADBEEF);
    end
    n_checks++;
    if (a_rd2 !== 32'h0) begin
      n_fail++;
      $display("FAIL a.read_data2 direct step %0d: got %h, expected %h", stp, a_rd2, 32'h0);
    end
    expect_val(S_RD1A, 64'hDEADBEEF); expect_val(S_RD2A, 0); expect_val(S_RD1B, 64'hDEADBEEF);
    step();
    wr(5'd0, 32'h1234); read_reg1 = 5'd0;
    expect_val(S_RD1A, 0); expect_val(S_RD1B, 0);
    step();
    read_reg1 = 5'd0;
    expect_val(S_RD1A, 0);
    step();

    // 2: bypass versus no bypass.
    wr(5'd7, 32'hA5A5A5A5); read_reg1 = 5'd7;
    #1;
    n_checks++;
    if (a_rd1 !== 32'hA5A5A5A5) begin
      n_fail++;
      $display("FAIL a.read_data1 bypass direct step %0d: got %h, expected %h", stp, a_rd1, 32'hA5A5A5A5);
    end
    n_checks++;
    if (b_rd1 !== 32'h0) begin
      n_fail++;
      $display("FAIL b.read_data1 bypass direct step %0d: got %h, expected %h", stp, b_rd1, 32'h0);
    end
    expect_val(S_RD1A, 64'hA5A5A5A5); expect_val(S_RD1B, 0);
    step();
    read_reg1 = 5'd7;
    expect_val(S_RD1A, 64'hA5A5A5A5); expect_val(S_RD1B, 64'hA5A5A5A5);
    step();

    // 3: scoreboard set, retire, set-beats-clear, different-register set+clear.
    sb_set = 1'b1; sb_reg = 5'd9; read_reg1 = 5'd9;
    expect_val(S_HZ1A, 0);
    step();
    expect_val(S_HZ1A, 1); expect_val(S_HZ1B, 1);
    step();
    wr(5'd9, 32'h99);
    expect_val(S_HZ1A, 0); expect_val(S_HZ1B, 1);
    step();
    expect_val(S_HZ1A, 0); expect_val(S_HZ1B, 0);
    step();
    wr(5'd9, 32'h1999); sb_set = 1'b1; sb_reg = 5'd9;
    expect_val(S_HZ1A, 0); expect_val(S_RD1A, 64'h1999); expect_val(S_RD1B, 64'h99);
    step();
    expect_val(S_HZ1A, 1); expect_val(S_HZ1B, 1); expect_val(S_RD1A, 64'h1999); expect_val(S_RD1B, 64'h1999);
    step();
    wr(5'd9, 32'h2999); sb_set = 1'b1; sb_reg = 5'd9; read_reg2 = 5'd9;
    expect_val(S_HZ1A, 1); expect_val(S_HZ2A, 1);
    step();
    wr(5'd9, 32'h3999); sb_set = 1'b1; sb_reg = 5'd10; read_reg2 = 5'd10;
    expect_val(S_HZ1A, 0); expect_val(S_HZ2A, 0); expect_val(S_HZ1B, 1);
    step();
    expect_val(S_HZ1A, 0); expect_val(S_HZ2A, 1); expect_val(S_HZ1B, 0); expect_val(S_RD1A, 64'h3999);
    step();

    // 4: full soft clear with a dropped mid-sweep write.
    for (int i = 1; i < 32; i++) begin
      wr(5'(i), 32'(i));
      step();
    end
    read_reg1 = 5'd17; read_reg2 = 5'd31;
    expect_val(S_RD1A, 17); expect_val(S_RD2A, 31);
    clr_req = 1'b1;
    expect_val(S_BUSYA, 0);
    step();
    for (int k = 0; k < 32; k++) begin
      if (k == 5) begin
        wr(5'd3, 32'hBAD); read_reg1 = 5'd3; read_reg2 = 5'd20;
        expect_val(S_RD1A, 0); expect_val(S_RD1B, 0); expect_val(S_RD2A, 20);
      end
      expect_val(S_BUSYA, 1); expect_val(S_BUSYB, 1);
      expect_val(S_DONEA, (k == 31) ? 1 : 0);
      step();
    end
    expect_val(S_BUSYA, 0); expect_val(S_DONEA, 0);
    for (int i = 0; i < 32; i++) begin
      read_reg1 = 5'(i); read_reg2 = 5'(i);
      expect_val(S_RD1A, 0); expect_val(S_HZ1A, 0); expect_val(S_RD1B, 0);
      step();
    end

    // 5: asynchronous reset in the middle of a clear.
    wr(5'd25, 32'h25);
    step();
    sb_set = 1'b1; sb_reg = 5'd25;
    step();
    read_reg1 = 5'd25; clr_req = 1'b1;
    step();
    for (int k = 0; k < 10; k++) begin
      expect_val(S_BUSYA, 1); expect_val(S_RD1A, 64'h25); expect_val(S_HZ1A, 1);
      step();
    end
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (a_rd1 !== 32'h0) begin
      n_fail++;
      $display("FAIL a.read_data1 reset direct step %0d: got %h, expected %h", stp, a_rd1, 32'h0);
    end
    n_checks++;
    if (a_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL a.clr_busy reset direct step %0d: got %b, expected %b", stp, a_busy, 1'b0);
    end
    n_checks++;
    if (a_done !== 1'b0) begin
      n_fail++;
      $display("FAIL a.clr_done reset direct step %0d: got %b, expected %b", stp, a_done, 1'b0);
    end
    expect_val(S_RD1A, 0); expect_val(S_HZ1A, 0); expect_val(S_BUSYA, 0); expect_val(S_DONEA, 0);
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 40; k++) begin
      expect_val(S_DONEA, 0); expect_val(S_BUSYA, 0);
      step();
    end
    wr(5'd4, 32'h4444);
    step();
    read_reg1 = 5'd4; read_reg2 = 5'd25;
    expect_val(S_RD1A, 64'h4444); expect_val(S_RD2A, 0);
    step();

    // 6: narrow instance, DATA_W=16 ADDR_W=3.
    for (int i = 0; i < 8; i++) begin
      c_reg_write = 1'b1; c_write_reg = 3'(i); c_write_data = 16'hFFFF;
      step();
    end
    for (int i = 0; i < 8; i++) begin
      c_read_reg1 = 3'(i); c_read_reg2 = 3'(7 - i);
      expect_val(S_RD1C, (i == 0) ? 0 : 64'hFFFF);
      expect_val(S_RD2C, (i == 7) ? 0 : 64'hFFFF);
      step();
    end
    c_sb_set = 1'b1; c_sb_reg = 3'd6;
    step();
    c_read_reg1 = 3'd6; c_clr_req = 1'b1;
    expect_val(S_BUSYC, 0); expect_val(S_HZ1C, 1);
    step();
    for (int k = 0; k < 8; k++) begin
      expect_val(S_BUSYC, 1); expect_val(S_DONEC, (k == 7) ? 1 : 0);
      step();
    end
    expect_val(S_BUSYC, 0); expect_val(S_DONEC, 0); expect_val(S_HZ1C, 0);
    for (int i = 0; i < 8; i++) begin
      c_read_reg1 = 3'(i);
      expect_val(S_RD1C, 0);
      step();
    end

    @(negedge clk);
    #1;
    if (n_checks < 12) begin
      n_fail++;
      $display("FAIL check count: got %0d, expected at least 12", n_checks);
    end
    if (n_fail == 0) begin
      $display("PASS: all checks passed");
    end else begin
      $display("FAIL: %0d failures", n_fail);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
